// File: rtl/rysy_pkg.sv
// Shared encodings for the fetch stage and the instruction-register stage.
package rysy_pkg;
    localparam int REG_LEN = 32;

    typedef enum logic [1:0] {
        INST_OLD = 2'b00,
        INST_NOP = 2'b01,
        INST_MEM = 2'b10
    } inst_sel_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } fetch_state_e;
endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: pc sequencing, branch flush and stall replay
// in front of a synchronous instruction memory.
module fetch_ctrl
    import rysy_pkg::*;
#(
    parameter logic [REG_LEN-1:0] RESET_VECTOR = 32'h00000000,
    parameter int unsigned        FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [REG_LEN-1:0] branch_target,
    input  logic               imem_ready,
    output logic [REG_LEN-1:0] imem_addr,
    output logic               imem_re,
    output logic [1:0]         inst_sel,
    output logic [REG_LEN-1:0] pc_inst
);
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    logic [REG_LEN-1:0] pc_q, pc_d;
    logic [REG_LEN-1:0] req_addr_q, req_addr_d;
    logic [REG_LEN-1:0] pc_inst_q, pc_inst_d;
    logic               rvalid_q, rvalid_d;
    logic [3:0]         flush_cnt_q, flush_cnt_d;
    fetch_state_e       state_q, state_d;

    assign imem_addr = pc_q;
    assign pc_inst   = pc_inst_q;

    always_comb begin
        inst_sel = INST_NOP;
        imem_re  = 1'b0;
        if (rst || branch_taken) begin
            inst_sel = INST_NOP;
        end else if (stall) begin
            inst_sel = INST_OLD;
        end else begin
            if (rvalid_q) inst_sel = INST_MEM;
            imem_re = (state_q == ST_RUN);
        end
    end

    always_comb begin
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        pc_inst_d   = pc_inst_q;
        rvalid_d    = rvalid_q;
        flush_cnt_d = flush_cnt_q;
        state_d     = state_q;
        if (branch_taken) begin
            pc_d        = branch_target & ~REG_LEN'(3);
            rvalid_d    = 1'b0;
            flush_cnt_d = FLUSH_INIT;
            state_d     = ST_FLUSH;
        end else if (stall) begin
            // Data returning during a stall cannot be latched; re-fetch it later.
            if (rvalid_q) begin
                pc_d     = req_addr_q;
                rvalid_d = 1'b0;
            end
        end else begin
            if (rvalid_q) pc_inst_d = req_addr_q;
            rvalid_d = 1'b0;
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN: begin
                    if (imem_ready) begin
                        req_addr_d = pc_q;
                        pc_d       = pc_q + REG_LEN'(4);
                        rvalid_d   = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == 4'd0) state_d = ST_RUN;
                    else                     flush_cnt_d = flush_cnt_q - 4'd1;
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_VECTOR;
            req_addr_q  <= RESET_VECTOR;
            pc_inst_q   <= RESET_VECTOR;
            rvalid_q    <= 1'b0;
            flush_cnt_q <= 4'd0;
            state_q     <= ST_BOOT;
        end else begin
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            pc_inst_q   <= pc_inst_d;
            rvalid_q    <= rvalid_d;
            flush_cnt_q <= flush_cnt_d;
            state_q     <= state_d;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; delivered instruction addresses are checked
// against a scoreboard of expected pc_inst values.
module tb_fetch_ctrl;
    localparam logic [1:0] OLD = 2'b00;
    localparam logic [1:0] NOP = 2'b01;
    localparam logic [1:0] MEM = 2'b10;

    logic        clk = 1'b0;
    logic        rst, stall, br, rdy;
    logic [31:0] tgt;
    logic [31:0] imem_addr, pc_inst;
    logic        imem_re;
    logic [1:0]  inst_sel;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(br),
        .branch_target(tgt), .imem_ready(rdy), .imem_addr(imem_addr),
        .imem_re(imem_re), .inst_sel(inst_sel), .pc_inst(pc_inst)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic b, input logic [31:0] t, input logic r);
        @(posedge clk); #1;
        rst = 1'b0; stall = s; br = b; tgt = t; rdy = r;
        #1;
    endtask

    task automatic chk_out(input logic [31:0] a, input logic r, input logic [1:0] s);
        chk("imem_addr", imem_addr, a);
        chk("imem_re", 32'(imem_re), 32'(r));
        chk("inst_sel", 32'(inst_sel), 32'(s));
    endtask

    // Reset cycle with stall and branch also asserted; reset must dominate.
    task automatic hold_reset();
        @(posedge clk); #1;
        rst = 1'b1; stall = 1'b1; br = 1'b1; tgt = 32'h0000_0abc; rdy = 1'b1;
        #1;
        chk("rst_sel", 32'(inst_sel), 32'(NOP));
        chk("rst_re", 32'(imem_re), 32'd0);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (inst_sel === MEM) begin
            @(posedge clk); #1;
            if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
            else                  chk("pc_inst", pc_inst, sb_q.pop_front());
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0; rdy = 1'b1;

        // First fetch after reset, then reset with a fetch outstanding
        hold_reset();
        step(0, 0, 0, 1); chk_out(32'h0, 0, NOP); chk("rst_pc_inst", pc_inst, 32'h0);
        sb_q.push_back(32'h0); sb_q.push_back(32'h4);
        step(0, 0, 0, 1); chk_out(32'h0, 1, NOP);
        step(0, 0, 0, 1); chk_out(32'h4, 1, MEM);
        step(0, 0, 0, 1); chk_out(32'h8, 1, MEM);
        hold_reset();

        // Branch in RUN to an unaligned target
        step(0, 0, 0, 1); chk_out(32'h0, 0, NOP);
        sb_q.push_back(32'h0);
        step(0, 0, 0, 1); chk_out(32'h0, 1, NOP);
        step(0, 0, 0, 1); chk_out(32'h4, 1, MEM);
        step(0, 1, 32'h103, 1); chk_out(32'h8, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'h100, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'h100, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'h100, 1, NOP);
        sb_q.push_back(32'h100);
        step(0, 0, 0, 1); chk_out(32'h104, 1, MEM);
        hold_reset();

        // Three-cycle stall while 0x20 is returning: replay
        step(0, 0, 0, 1); chk_out(32'h0, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'h0, 1, NOP);
        step(0, 1, 32'h20, 1); chk_out(32'h4, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'h20, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'h20, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'h20, 1, NOP);
        step(1, 0, 0, 1); chk_out(32'h24, 0, OLD);
        step(1, 0, 0, 1); chk_out(32'h20, 0, OLD);
        step(1, 0, 0, 1); chk_out(32'h20, 0, OLD);
        step(0, 0, 0, 1); chk_out(32'h20, 1, NOP);
        sb_q.push_back(32'h20); sb_q.push_back(32'h24);
        step(0, 0, 0, 1); chk_out(32'h24, 1, MEM);
        step(0, 0, 0, 1); chk_out(32'h28, 1, MEM);
        hold_reset();

        // Memory not ready for two cycles at 0x40
        step(0, 0, 0, 1); chk_out(32'h0, 0, NOP);
        step(0, 1, 32'h40, 1); chk_out(32'h0, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'h40, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'h40, 0, NOP);
        step(0, 0, 0, 0); chk_out(32'h40, 1, NOP);
        step(0, 0, 0, 0); chk_out(32'h40, 1, NOP);
        step(0, 0, 0, 1); chk_out(32'h40, 1, NOP);
        sb_q.push_back(32'h40);
        step(0, 0, 0, 1); chk_out(32'h44, 1, MEM);
        hold_reset();

        // Stall and branch together: branch wins
        step(0, 0, 0, 1); chk_out(32'h0, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'h0, 1, NOP);
        step(1, 1, 32'h200, 1); chk_out(32'h4, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'h200, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'h200, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'h200, 1, NOP);
        sb_q.push_back(32'h200);
        step(0, 0, 0, 1); chk_out(32'h204, 1, MEM);
        hold_reset();

        // Branch during FLUSH restarts the count; stall freezes it
        step(0, 0, 0, 1); chk_out(32'h0, 0, NOP);
        step(0, 1, 32'h80, 1); chk_out(32'h0, 0, NOP);
        step(0, 1, 32'h90, 1); chk_out(32'h80, 0, NOP);
        step(1, 0, 0, 1); chk_out(32'h90, 0, OLD);
        step(0, 0, 0, 1); chk_out(32'h90, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'h90, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'h90, 1, NOP);
        sb_q.push_back(32'h90);
        step(0, 0, 0, 1); chk_out(32'h94, 1, MEM);
        hold_reset();

        // pc wrap at the top of the address space
        step(0, 0, 0, 1); chk_out(32'h0, 0, NOP);
        step(0, 1, 32'hFFFF_FFFF, 1); chk_out(32'h0, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'hFFFF_FFFC, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'hFFFF_FFFC, 0, NOP);
        step(0, 0, 0, 1); chk_out(32'hFFFF_FFFC, 1, NOP);
        sb_q.push_back(32'hFFFF_FFFC); sb_q.push_back(32'h0);
        step(0, 0, 0, 1); chk_out(32'h0, 1, MEM);
        step(0, 0, 0, 1); chk_out(32'h4, 1, MEM);
        hold_reset();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
